stream_mux_rr: RTL
==================

// Module: stream_mux_rr
//
// PURPOSE
// - N-channel registered stream multiplexer; parametrised successor of the combinational mux_N_1 blocks.
// - Selects one of N_CH valid/ready input streams by internal arbitration, not by an external sel.
// - Drives a single registered output stream, plus the index of the channel the word came from.
// - Sits between several producers and one shared consumer (e.g. result bus, display, UART tx).
//
// PARAMETERS
// - N_CH   4                    number of input channels; legal range >= 2, need not be a power of two
// - WIDTH  4                    data width per channel, in bits
// - SEL_W  $clog2(N_CH)         width of out_sel; derived, do not override
//
// PORTS
// - clk        in   1            single clock, rising edge
// - rst        in   1            asynchronous, active-high reset
// - in_valid   in   N_CH         bit i: channel i presents a word
// - in_data    in   N_CH*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
// - in_ready   out  N_CH         bit i: channel i's word is taken this cycle
// - out_valid  out  1            output register holds a word
// - out_data   out  WIDTH        registered word
// - out_sel    out  SEL_W        index of the source channel of out_data
// - out_ready  in   1            consumer takes the word this cycle
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - out_valid=0, out_data=0, out_sel=0, rr pointer=0 (ch0 has top priority).
//   - in_ready is all-zero while rst=1.
// - load_en = !out_valid | out_ready.
// - Word transfer: the word moves only in a cycle where valid & ready are both 1.
// - Arbitration:
//   - Combinational over in_valid, starting at pointer p.
//   - Search order is p, p+1, ..., N_CH-1, 0, ..., p-1.
//   - The first channel with in_valid=1 is the grant g.
// - in_ready[g] = load_en. All other in_ready bits are 0. At most one bit is set.
// - in_ready may depend on in_valid.
// - On accept (load_en & any in_valid), at the next edge:
//   - out_valid=1, out_data=in_data[g], out_sel=g.
//   - p = (g == N_CH-1) ? 0 : g+1. This wraps correctly for non-power-of-two N_CH.
// - Drain with no new input (out_ready=1, no in_valid): out_valid<=0; out_data and out_sel hold their values.
// - Output stall (out_valid=1, out_ready=0):
//   - out_data and out_sel are stable.
//   - All in_ready bits are 0.
//   - p does not change.
// - Drain and load in the same cycle: output is reloaded at the same edge. No bubble; 1 word/cycle sustained.
// - Latency: 1 cycle from the input handshake to out_valid.
// - Producer rule: in_valid and in_data must stay stable until in_ready. The block does not check this.
// - Fairness: with all channels continuously valid, grants cycle 0,1,...,N_CH-1,0,...
// - Reset mid-operation: the held word is discarded, out_valid drops immediately, p returns to 0.
//
// CONFIGURATION
// - Macro STREAM_MUX_FIXED_PRIO_EN.
// - Defined:
//   - Fixed priority: the lowest-index valid channel always wins.
//   - The rr pointer register is not synthesised.
//   - All other behaviour is unchanged.
// - Undefined (default): round-robin as described in BEHAVIOUR.
//
// TESTING
// - Reset: assert rst mid-transfer
//   -> out_valid=0, out_data=0, out_sel=0, in_ready=0 immediately; after release ch0 has top priority.
// - Single channel, N_CH=4, WIDTH=4: in_valid=4'b0100, in_data[2]=4'hA, out_ready=1
//   -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_sel=2.
// - All valid, out_ready=1 held, data[i]=i+1
//   -> out_sel sequence 0,1,2,3,0; out_data 1,2,3,4,1; one word per cycle.
//   -> With STREAM_MUX_FIXED_PRIO_EN defined: out_sel stays 0.
// - Stall: out_valid=1 (out_data=4'h5), out_ready=0 for 3 cycles, ch1 and ch3 valid
//   -> in_ready=0 and out_data stays 4'h5;
//   -> after out_ready=1, the winner follows pointer order from the last grant.
// - Wrap, N_CH=3: last grant ch2, then in_valid=3'b011
//   -> grant ch0 (p wrapped to 0), out_sel=0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-channel valid/ready stream multiplexer with a registered
// output stage. Channels are selected by round-robin arbitration; the output
// carries the word and the index of the channel it came from.
// Build option: define STREAM_MUX_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer register).
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
`ifndef STREAM_MUX_FIXED_PRIO_EN
  logic [SEL_W-1:0] ptr_q,       ptr_d;
`endif

  logic             load_en;
  logic             any_valid;
  logic [SEL_W-1:0] grant;
  logic [N_CH-1:0]  grant_oh;
  logic [WIDTH-1:0] grant_data;
  int               best_d;
  int               cur_d;

  // The output register can take a new word when empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Arbitration: the valid channel with the smallest search distance from
  // the pointer wins; the distance wraps modulo N_CH so any N_CH works.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    any_valid  = 1'b0;
    grant      = '0;
    grant_oh   = '0;
    grant_data = '0;
    best_d     = N_CH;
    cur_d      = 0;
    for (int i = 0; i < N_CH; i++) begin
`ifdef STREAM_MUX_FIXED_PRIO_EN
      cur_d = i;
`else
      cur_d = (i >= int'(ptr_q)) ? i - int'(ptr_q) : i + N_CH - int'(ptr_q);
`endif
      if (in_valid[i] && (cur_d < best_d)) begin
        best_d      = cur_d;
        any_valid   = 1'b1;
        grant       = SEL_W'(i);
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the granted channel sees ready, and only when the output can load;
  // held low throughout reset.
  assign in_ready = (load_en && !rst) ? grant_oh : '0;

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
`ifndef STREAM_MUX_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (load_en) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant;
`ifndef STREAM_MUX_FIXED_PRIO_EN
        ptr_d       = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + 1'b1;
`endif
      end else begin
        // Drain with nothing to load: data and sel keep their last value.
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
`ifndef STREAM_MUX_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
`ifndef STREAM_MUX_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
